// File: rtl/sar_pkg.sv
// Shared types and slot timing for the SAR ADC controller.
// SAR_CMP_SYNC_EN lengthens each bit slot to cover the comparator synchronizer.
package sar_pkg;

  typedef enum logic [1:0] {IDLE, SAMPLE, CONVERT, DONE} state_t;

  localparam int unsigned SYNC_STAGES = 2;

  // Bit-slot length in cycles; the synchronizer delay is absorbed into every slot.
  function automatic int unsigned slot_len(input int unsigned settle_cycles);
`ifdef SAR_CMP_SYNC_EN
    return settle_cycles + SYNC_STAGES;
`else
    return settle_cycles;
`endif
  endfunction

endpackage

// File: rtl/sar_cmp_sync.sv
// Two-flop synchronizer for the asynchronous comparator decision.
// Instantiated by sar_adc_ctrl only when SAR_CMP_SYNC_EN is defined.
module sar_cmp_sync
  import sar_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] ff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ff <= '0;
    else        ff <= {ff[SYNC_STAGES-2:0], d};
  end

  assign q = ff[SYNC_STAGES-1];

endmodule

// File: rtl/sar_adc_ctrl.sv
// Successive-approximation controller: sample phase, MSB-first bit trials, result capture.
// Define SAR_CMP_SYNC_EN to route cmp_in through a 2-flop synchronizer (longer bit slots).
module sar_adc_ctrl
  import sar_pkg::*;
#(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned SAMPLE_CYCLES = 4,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             start,
  input  logic             cmp_in,
  output logic             sample,
  output logic [WIDTH-1:0] dac_code,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int unsigned SLOT    = slot_len(SETTLE_CYCLES);
  localparam int unsigned CNT_MAX = (SAMPLE_CYCLES > SLOT) ? SAMPLE_CYCLES : SLOT;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned IDX_W   = $clog2(WIDTH);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx;
  logic [WIDTH-1:0] code;
  logic             cmp_dec;
  logic [WIDTH-1:0] mask_c;
  logic [WIDTH-1:0] keep_c;

`ifdef SAR_CMP_SYNC_EN
  sar_cmp_sync u_cmp_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (cmp_in),
    .q     (cmp_dec)
  );
`else
  assign cmp_dec = cmp_in;
`endif

  // Bit under trial and the code after this slot's decision.
  assign mask_c = WIDTH'(1) << idx;
  assign keep_c = cmp_dec ? (code | mask_c) : (code & ~mask_c);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      idx      <= '0;
      code     <= '0;
      sample   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      dac_code <= '0;
      result   <= '0;
    end else begin
      done <= 1'b0;
      if (!ena) begin
        state    <= IDLE;
        sample   <= 1'b0;
        busy     <= 1'b0;
        dac_code <= '0;
      end else begin
        case (state)
          IDLE: begin
            dac_code <= '0;
            if (start) begin
              state  <= SAMPLE;
              cnt    <= CNT_W'(SAMPLE_CYCLES - 1);
              sample <= 1'b1;
              busy   <= 1'b1;
            end
          end
          SAMPLE: begin
            if (cnt == '0) begin
              state    <= CONVERT;
              sample   <= 1'b0;
              idx      <= IDX_W'(WIDTH - 1);
              code     <= '0;
              cnt      <= CNT_W'(SLOT - 1);
              dac_code <= WIDTH'(1) << (WIDTH - 1);
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
          CONVERT: begin
            if (cnt == '0) begin
              code <= keep_c;
              if (idx == '0) begin
                state    <= DONE;
                done     <= 1'b1;
                result   <= keep_c;
                dac_code <= keep_c;
              end else begin
                idx      <= idx - IDX_W'(1);
                cnt      <= CNT_W'(SLOT - 1);
                dac_code <= keep_c | (mask_c >> 1);
              end
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
          DONE: begin
            // A held start relaunches straight from DONE so conversions run back-to-back.
            if (start) begin
              state    <= SAMPLE;
              cnt      <= CNT_W'(SAMPLE_CYCLES - 1);
              sample   <= 1'b1;
              dac_code <= '0;
            end else begin
              state    <= IDLE;
              busy     <= 1'b0;
              dac_code <= '0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Self-checking bench for sar_adc_ctrl with a behavioural comparator (cmp_in = vin >= dac_code).
// Expected latency follows SAR_CMP_SYNC_EN when the bundle is built with it.
module tb_sar_adc_ctrl;

  localparam int unsigned W  = 8;
  localparam int unsigned SC = 4;
  localparam int unsigned ST = 2;
`ifdef SAR_CMP_SYNC_EN
  localparam int unsigned SLOT = ST + 2;
`else
  localparam int unsigned SLOT = ST;
`endif
  localparam int unsigned LAT = SC + W * SLOT;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         ena   = 1'b0;
  logic         start = 1'b0;
  logic         cmp_in;
  logic [W-1:0] vin   = '0;
  logic         sample;
  logic [W-1:0] dac_code;
  logic         busy;
  logic         done;
  logic [W-1:0] result;

  typedef struct {
    logic [W-1:0] res;
    int unsigned  at;
  } exp_t;

  typedef struct {
    logic [W-1:0] vin;
    logic [W-1:0] res;
  } vec_t;

  exp_t        sb[$];
  int unsigned cyc   = 0;
  int          total = 0;
  int          bad   = 0;

  sar_adc_ctrl #(.WIDTH(W), .SAMPLE_CYCLES(SC), .SETTLE_CYCLES(ST)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .start    (start),
    .cmp_in   (cmp_in),
    .sample   (sample),
    .dac_code (dac_code),
    .busy     (busy),
    .done     (done),
    .result   (result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always_comb cmp_in = (vin >= dac_code);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest pending expectation.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (rst_n && done === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done at cycle %0d want none", cyc);
      end else begin
        e = sb.pop_front();
        chk("done_result", 32'(result), 32'(e.res));
        chk("done_dac", 32'(dac_code), 32'(e.res));
        chk("done_cycle", cyc, e.at);
        chk("done_busy", 32'(busy), 32'd1);
      end
    end
  end

  // Single start pulse; checks sample width, each trial code, and busy dropping after DONE.
  task automatic run_conv(input logic [W-1:0] v, input logic [W-1:0] exp_res);
    int unsigned  c0;
    int unsigned  off;
    int           nsamp;
    int           bitn;
    logic [W-1:0] code;
    logic [W-1:0] trial;
    logic [W-1:0] one;
    vin = v;
    @(negedge clk);
    start = 1'b1;
    c0 = cyc + 1;
    sb.push_back('{exp_res, c0 + LAT});
    nsamp = 0;
    code  = '0;
    one   = W'(1);
    for (int j = 0; j <= int'(LAT) + 2; j++) begin
      @(posedge clk);
      #1;
      if (j == 0) start = 1'b0;
      off = cyc - c0;
      if (sample) nsamp++;
      if (off >= SC && off < LAT && ((off - SC) % SLOT) == 0) begin
        bitn  = int'(W) - 1 - int'((off - SC) / SLOT);
        trial = code | (one << bitn);
        chk("trial_code", 32'(dac_code), 32'(trial));
        if (v >= trial) code = trial;
      end
      if (off == LAT + 1) chk("busy_after_done", 32'(busy), 32'd0);
    end
    chk("sample_cycles", 32'(nsamp), 32'(SC));
    chk("done_seen", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    vec_t        vt[7];
    int unsigned c0;
    int unsigned off;
    logic [W-1:0] prev;

    vt[0] = '{8'hA5, 8'hA5};
    vt[1] = '{8'h00, 8'h00};
    vt[2] = '{8'hFF, 8'hFF};
    vt[3] = '{8'h5A, 8'h5A};
    vt[4] = '{8'h01, 8'h01};
    vt[5] = '{8'h80, 8'h80};
    vt[6] = '{8'h7F, 8'h7F};

    // Reset values
    ena = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sample", 32'(sample), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_dac", 32'(dac_code), 0);
    chk("rst_result", 32'(result), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Table-driven single conversions
    for (int i = 0; i < 7; i++) run_conv(vt[i].vin, vt[i].res);

    // Back-to-back with start held high
    vin = 8'h3C;
    @(negedge clk);
    start = 1'b1;
    c0 = cyc + 1;
    for (int k = 0; k < 3; k++) sb.push_back('{8'h3C, c0 + LAT + k * (LAT + 1)});
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (sb.size() == 0) break;
    end
    start = 1'b0;
    chk("b2b_all_done", 32'(sb.size()), 0);
    repeat (LAT + 5) @(negedge clk);
    chk("b2b_idle", 32'(busy), 0);

    // Start pulsed mid-conversion is ignored
    vin = 8'hA5;
    @(negedge clk);
    start = 1'b1;
    c0 = cyc + 1;
    sb.push_back('{8'hA5, c0 + LAT});
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int k = 0; k < int'(LAT) + 6; k++) begin
      @(posedge clk);
      #1;
      off = cyc - c0;
      start = (off == SC + 4);
    end
    start = 1'b0;
    chk("ignore_start_single_done", 32'(sb.size()), 0);
    chk("ignore_start_idle", 32'(busy), 0);

    // ena low mid-conversion aborts without done
    prev = result;
    vin  = 8'h33;
    @(negedge clk);
    start = 1'b1;
    c0 = cyc + 1;
    do begin
      @(posedge clk);
      #1;
      start = 1'b0;
    end while (cyc - c0 < 10);
    ena = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_sample", 32'(sample), 0);
    chk("abort_dac", 32'(dac_code), 0);
    chk("abort_result", 32'(result), 32'(prev));
    repeat (LAT + 5) @(negedge clk);
    ena = 1'b1;
    repeat (2) @(negedge clk);
    chk("abort_result_held", 32'(result), 32'(prev));

    // Async reset mid-conversion
    vin = 8'h96;
    @(negedge clk);
    start = 1'b1;
    c0 = cyc + 1;
    do begin
      @(posedge clk);
      #1;
      start = 1'b0;
    end while (cyc - c0 < 12);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_sample", 32'(sample), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_done", 32'(done), 0);
    chk("mid_rst_dac", 32'(dac_code), 0);
    chk("mid_rst_result", 32'(result), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_conv(8'h96, 8'h96);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want test completion");
    $fatal(1, "watchdog expired");
  end

endmodule
